// File: rtl/pulse_generator_bank_pkg.sv
// Shared types for the multi-channel pulse/PWM generator.
// Mode and state enums plus a channel-select width helper.
package pulse_pkg;

   typedef enum logic {
      MODE_PERIODIC = 1'b0,
      MODE_ONESHOT  = 1'b1
   } pulse_mode_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } pulse_state_t;

   function automatic int unsigned ch_bits(input int unsigned ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

endpackage

// File: rtl/pulse_generator_bank_if.sv
// Config write port and pulse outputs of the generator bank.
// master drives stimulus/config, slave is the bank itself.
interface pulse_generator_bank_if
   import pulse_pkg::*;
#(
   parameter int N        = 8,
   parameter int CHANNELS = 4,
   parameter int CW       = ch_bits(CHANNELS)
) ();

   logic                ena;
   logic [CHANNELS-1:0] ch_en;
   logic [CHANNELS-1:0] trigger;
   logic                cfg_wr;
   logic [CW-1:0]       cfg_ch;
   logic [N-1:0]        cfg_period;
   logic [N-1:0]        cfg_width;
   logic                cfg_mode;
   logic [CHANNELS-1:0] out;
   logic [CHANNELS-1:0] wrap;
   logic [CHANNELS-1:0] busy;

   modport master (
      output ena, ch_en, trigger,
      output cfg_wr, cfg_ch,
      output cfg_period, cfg_width, cfg_mode,
      input  out, wrap, busy
   );

   modport slave (
      input  ena, ch_en, trigger,
      input  cfg_wr, cfg_ch,
      input  cfg_period, cfg_width, cfg_mode,
      output out, wrap, busy
   );

endinterface

// File: rtl/pulse_generator_bank_channel.sv
// One pulse channel: shadow/active config, IDLE/RUN FSM,
// tick counter and output decode.
module pulse_channel
   import pulse_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         ena_i,
   input  logic         ch_en_i,
   input  logic         trig_i,
   input  logic         wr_i,
   input  logic [N-1:0] period_i,
   input  logic [N-1:0] width_i,
   input  pulse_mode_t  mode_i,
   output logic         out_o,
   output logic         wrap_o,
   output logic         busy_o
);

   typedef struct packed {
      logic [N-1:0] period;
      logic [N-1:0] width;
      pulse_mode_t  mode;
   } pulse_cfg_t;

   localparam pulse_cfg_t CFG_RST = '{
      period: '0,
      width:  '0,
      mode:   MODE_PERIODIC
   };

   pulse_cfg_t   sh_q;
   pulse_cfg_t   act_q;
   pulse_cfg_t   cfg_in;
   pulse_cfg_t   inc;
   pulse_state_t state_q;
   logic [N-1:0] cnt_q;
   logic         run;
   logic         last;
   logic         start;
   logic         stay;

   assign cfg_in = '{
      period: period_i,
      width:  width_i,
      mode:   mode_i
   };

   // A write landing on a load cycle bypasses the shadow.
   assign inc   = wr_i ? cfg_in : sh_q;
   assign run   = (state_q == S_RUN);
   assign last  = (cnt_q == act_q.period - N'(1));
   assign start = (inc.period != '0) &&
                  ((inc.mode == MODE_PERIODIC) || trig_i);
   assign stay  = (inc.period != '0) &&
                  (inc.mode == MODE_PERIODIC);

   assign out_o  = run && (cnt_q < act_q.width);
   assign wrap_o = run && ch_en_i && ena_i && last;
   assign busy_o = run;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_q    <= CFG_RST;
         act_q   <= CFG_RST;
      end else begin
         if (wr_i) sh_q <= cfg_in;
         unique case (state_q)
            S_IDLE: begin
               act_q <= inc;
               cnt_q <= '0;
               if (ch_en_i && start) state_q <= S_RUN;
            end
            S_RUN: begin
               if (!ch_en_i) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else if (ena_i) begin
                  if (last) begin
                     cnt_q <= '0;
                     act_q <= inc;
                     if (!stay) state_q <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q + N'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/pulse_generator_bank.sv
// Bank of independent pulse/PWM channels sharing one
// config write port and a common advance tick.
module pulse_generator_bank
   import pulse_pkg::*;
#(
   parameter int N        = 8,
   parameter int CHANNELS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   pulse_generator_bank_if.slave bus
);

   localparam int CW = ch_bits(CHANNELS);

   logic [CHANNELS-1:0] wr_en;
   logic [CHANNELS-1:0] out_w;
   logic [CHANNELS-1:0] wrap_w;
   logic [CHANNELS-1:0] busy_w;

   // Out-of-range channel numbers match no channel.
   always_comb begin
      wr_en = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_en[i] = bus.cfg_wr && (bus.cfg_ch == CW'(i));
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      pulse_channel #(.N(N)) u_ch (
         .clk_i    (clk),
         .rst_ni   (rst),
         .ena_i    (bus.ena),
         .ch_en_i  (bus.ch_en[i]),
         .trig_i   (bus.trigger[i]),
         .wr_i     (wr_en[i]),
         .period_i (bus.cfg_period),
         .width_i  (bus.cfg_width),
         .mode_i   (pulse_mode_t'(bus.cfg_mode)),
         .out_o    (out_w[i]),
         .wrap_o   (wrap_w[i]),
         .busy_o   (busy_w[i])
      );
   end

   assign bus.out  = out_w;
   assign bus.wrap = wrap_w;
   assign bus.busy = busy_w;

endmodule
